// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling from a two-flop synchronized line,
// received bytes presented on a single-beat AXI-Stream master with error/overrun pulses.
module uart_rx #(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       rxbyte_tvalid,
  input  logic       rxbyte_tready,
  output logic [7:0] rxbyte_tdata,
  output logic       rxbyte_tkeep,
  output logic       frame_error,
  output logic       overrun
);

`ifdef SIMULATION
  localparam bit SIM_BUILD = 1'b1;
`else
  localparam bit SIM_BUILD = 1'b0;
`endif

  localparam int USED_BAUD_RATE = SIM_BUILD ? BAUD_RATE_SIM : BAUD_RATE;
  localparam int TICS_PER_BEAT  = ACLK_FREQUENCY / USED_BAUD_RATE;
  localparam int HALF_BEAT      = TICS_PER_BEAT / 2;
  localparam int CNT_W          = (TICS_PER_BEAT > 2) ? $clog2(TICS_PER_BEAT) : 1;

  localparam logic [CNT_W-1:0] TIC_FULL = CNT_W'(TICS_PER_BEAT - 1);
  localparam logic [CNT_W-1:0] TIC_HALF = CNT_W'(HALF_BEAT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] tic;
  logic [2:0]       bit_cnt;
  logic             rxd_meta;
  logic             rxd_s;
  logic [7:0]       shift_reg;
  logic             shift_en;

  assign rxbyte_tkeep = 1'b1;
  assign shift_en     = (state == DATA) && (tic == '0);

  // Shift register is pure datapath; it is only ever read after eight fresh samples.
  always_ff @(posedge aclk) begin
    if (shift_en) shift_reg <= {rxd_s, shift_reg[7:1]};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      tic           <= '0;
      bit_cnt       <= '0;
      rxd_meta      <= 1'b1;
      rxd_s         <= 1'b1;
      rxbyte_tvalid <= 1'b0;
      rxbyte_tdata  <= '0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rxd_meta    <= uart_rxd;
      rxd_s       <= rxd_meta;
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      if (rxbyte_tvalid && rxbyte_tready) rxbyte_tvalid <= 1'b0;
      if (tic != '0) tic <= tic - CNT_W'(1);

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            tic   <= TIC_HALF;
            state <= START;
          end
        end
        START: begin
          if (tic == '0) begin
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              tic     <= TIC_FULL;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (tic == '0) begin
            tic     <= TIC_FULL;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tic == '0) begin
            if (rxd_s) begin
              // A byte still waiting for its sink wins; the new one is dropped.
              if (!rxbyte_tvalid || rxbyte_tready) begin
                rxbyte_tdata  <= shift_reg;
                rxbyte_tvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 4 aclks per bit: directed frames, scoreboard queue of expected
// bytes popped by an independent monitor on every AXI-Stream handshake.
module tb_uart_rx;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       uart_rxd;
  logic       rxbyte_tvalid;
  logic       rxbyte_tready;
  logic [7:0] rxbyte_tdata;
  logic       rxbyte_tkeep;
  logic       frame_error;
  logic       overrun;

  uart_rx #(
    .ACLK_FREQUENCY(200000000),
    .BAUD_RATE(50000000),
    .BAUD_RATE_SIM(50000000)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .uart_rxd(uart_rxd),
    .rxbyte_tvalid(rxbyte_tvalid),
    .rxbyte_tready(rxbyte_tready),
    .rxbyte_tdata(rxbyte_tdata),
    .rxbyte_tkeep(rxbyte_tkeep),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcycles = 0;
  int start_cyc = 0;
  bit lat_en = 1'b0;
  bit toggle_ready = 1'b0;
  bit ready_level = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Frame at 4 aclks per bit; rst_bit selects a data bit during which reset is pulsed.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
    uart_rxd  = 1'b0;
    start_cyc = cyc;
    hold(4);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      if (i == rst_bit) begin
        hold(2);
        aresetn = 1'b0;
        hold(2);
        aresetn = 1'b1;
      end else begin
        hold(4);
      end
    end
    uart_rxd = stop;
    hold(4);
  endtask

  initial begin
    rxbyte_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_ready) rxbyte_tready = ~rxbyte_tready;
      else rxbyte_tready = ready_level;
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_valid;
    prev_hold  = 1'b0;
    prev_data  = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge aclk);
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rxbyte_tvalid) vcycles++;
      if (lat_en && rxbyte_tvalid && !prev_valid) check("latency", cyc - start_cyc, 41);
      if (prev_hold && rxbyte_tvalid) check("tdata_stable", int'(rxbyte_tdata), int'(prev_data));
      if (rxbyte_tvalid && rxbyte_tready) begin
        check("xfer_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tdata", int'(rxbyte_tdata), int'(exp_q.pop_front()));
        check("tkeep", int'(rxbyte_tkeep), 1);
      end
      prev_hold  = rxbyte_tvalid && !rxbyte_tready;
      prev_data  = rxbyte_tdata;
      prev_valid = rxbyte_tvalid;
    end
  end

  initial begin
    int fe0, ov0, v0, waited;
    aresetn  = 1'b0;
    uart_rxd = 1'b1;
    hold(3);
    check("rst_tvalid", int'(rxbyte_tvalid), 0);
    check("rst_tdata", int'(rxbyte_tdata), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_overrun", int'(overrun), 0);
    aresetn = 1'b1;
    hold(5);

    // Single frame, sink always ready
    v0 = vcycles; fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    lat_en = 1'b1;
    send_frame(8'hA5, 1'b1, -1);
    hold(10);
    lat_en = 1'b0;
    check("a5_valid_cycles", vcycles - v0, 1);
    check("a5_frame_error", fe_cnt - fe0, 0);
    check("a5_overrun", ov_cnt - ov0, 0);

    // Back-to-back frames under backpressure
    ready_level = 1'b0;
    hold(2);
    ov0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    hold(10);
    check("bp_tvalid_held", int'(rxbyte_tvalid), 1);
    check("bp_tdata_held", int'(rxbyte_tdata), 8'h3C);
    check("bp_overrun_once", ov_cnt - ov0, 1);
    ready_level = 1'b1;
    hold(5);
    check("bp_tvalid_cleared", int'(rxbyte_tvalid), 0);

    // Stop bit low followed by a break
    fe0 = fe_cnt; v0 = vcycles;
    send_frame(8'h55, 1'b0, -1);
    uart_rxd = 1'b0;
    hold(40);
    uart_rxd = 1'b1;
    hold(10);
    check("break_frame_error_once", fe_cnt - fe0, 1);
    check("break_no_valid", vcycles - v0, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1);
    hold(10);

    // Short low glitch on an idle line
    fe0 = fe_cnt; v0 = vcycles;
    uart_rxd = 1'b0;
    hold(1);
    uart_rxd = 1'b1;
    hold(20);
    check("glitch_no_frame_error", fe_cnt - fe0, 0);
    check("glitch_no_valid", vcycles - v0, 0);

    // Reset during data bit 4
    v0 = vcycles;
    send_frame(8'hFF, 1'b1, 4);
    hold(10);
    check("reset_no_valid", vcycles - v0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    hold(10);

    // Sink toggling ready every cycle
    ov0 = ov_cnt;
    toggle_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    hold(10);
    toggle_ready = 1'b0;
    ready_level  = 1'b1;
    check("toggle_no_overrun", ov_cnt - ov0, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      hold(1);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("total_frame_errors", fe_cnt, 1);
    check("total_overruns", ov_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
